// File: rtl/alu_byte_sequencer.sv
// Issue/collect stage that walks an external 8-bit ALU over a BYTES-wide operation, LSB first.
// Define ALU_BYTE_SEQUENCER_OVF_EN to build signed-overflow detection into rsp_flags[3].
module alu_byte_sequencer #(
    parameter int unsigned BYTES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [8*BYTES-1:0]   req_a,
    input  logic [8*BYTES-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [8*BYTES-1:0]   rsp_d,
    output logic [7:0]           rsp_flags,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [7:0]           alu_fi,
    output logic [6:0]           alu_op,
    input  logic [7:0]           alu_d,
    input  logic [7:0]           alu_fo
);

    localparam int unsigned W  = 8 * BYTES;
    localparam int unsigned IW = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [IW-1:0] LastIdx = IW'(BYTES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpAdc = 3'd1;
    localparam logic [2:0] OpSub = 3'd2;
    localparam logic [2:0] OpSbc = 3'd3;
    localparam logic [2:0] OpAnd = 3'd4;
    localparam logic [2:0] OpOr  = 3'd5;
    localparam logic [2:0] OpNot = 3'd6;
    localparam logic [2:0] OpRsv = 3'd7;

    localparam logic [6:0] AluAdd = 7'b0000001;
    localparam logic [6:0] AluSub = 7'b0000010;
    localparam logic [6:0] AluAnd = 7'b0000100;
    localparam logic [6:0] AluOr  = 7'b0001000;
    localparam logic [6:0] AluNot = 7'b0010000;

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          chain_q, chain_d;
    logic          zero_q, zero_d;
    logic [W-1:0]  res_q, res_d;
    logic [7:0]    flags_q, flags_d;
    logic          carry_q, carry_d;

    logic          is_arith;
    logic          is_sub;
    logic          zero_final;
    logic          ovf_final;
    logic [7:0]    flags_final;

    // Flag bits 7:1 of the ALU are not part of the chaining contract.
    logic unused_fo;
    assign unused_fo = ^alu_fo[7:1];

    assign is_arith = ~op_q[2];
    assign is_sub   = op_q[1];

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StDone);
    assign rsp_d     = res_q;
    assign rsp_flags = flags_q;

    // ALU drive is purely combinational and only active while walking bytes.
    always_comb begin
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        alu_fi = 8'h00;
        alu_op = 7'b0000000;
        if (state_q == StRun) begin
            alu_a  = a_q[{idx_q, 3'b000} +: 8];
            alu_b  = b_q[{idx_q, 3'b000} +: 8];
            alu_fi = {7'b0000000, chain_q};
            unique case (op_q)
                OpAdd, OpAdc: alu_op = AluAdd;
                OpSub, OpSbc: alu_op = AluSub;
                OpAnd:        alu_op = AluAnd;
                OpOr:         alu_op = AluOr;
                OpNot:        alu_op = AluNot;
                default:      alu_op = 7'b0000000;
            endcase
        end
    end

    assign zero_final = zero_q & (alu_d == 8'h00);

`ifdef ALU_BYTE_SEQUENCER_OVF_EN
    // Signed overflow from operand MSBs and the MSB of the last (most significant) byte.
    always_comb begin
        ovf_final = 1'b0;
        if (is_arith) begin
            if (is_sub) begin
                ovf_final = (a_q[W-1] != b_q[W-1]) && (alu_d[7] != a_q[W-1]);
            end else begin
                ovf_final = (a_q[W-1] == b_q[W-1]) && (alu_d[7] != a_q[W-1]);
            end
        end
    end
`else
    assign ovf_final = 1'b0;
    logic unused_sub;
    assign unused_sub = is_sub;
`endif

    always_comb begin
        flags_final    = 8'h00;
        flags_final[0] = is_arith ? alu_fo[0] : carry_q;
        flags_final[1] = zero_final;
        flags_final[2] = ~alu_d[7] & ~zero_final;
        flags_final[3] = ovf_final;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        chain_d = chain_q;
        zero_d  = zero_q;
        res_d   = res_q;
        flags_d = flags_q;
        carry_d = carry_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    idx_d   = '0;
                    zero_d  = 1'b1;
                    chain_d = ((req_op == OpAdc) || (req_op == OpSbc)) ? carry_q : 1'b0;
                    if (req_op == OpRsv) begin
                        res_d   = '0;
                        flags_d = 8'h82;
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                res_d[{idx_q, 3'b000} +: 8] = alu_d;
                zero_d = zero_final;
                if (is_arith) begin
                    chain_d = alu_fo[0];
                end
                if (idx_q == LastIdx) begin
                    flags_d = flags_final;
                    if (is_arith) begin
                        carry_d = alu_fo[0];
                    end
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            chain_q <= 1'b0;
            zero_q  <= 1'b0;
            res_q   <= '0;
            flags_q <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            chain_q <= chain_d;
            zero_q  <= zero_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Directed bench for alu_byte_sequencer (BYTES=2) with a behavioural 8-bit ALU attached.
module tb_alu_byte_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_d;
    logic [7:0]  rsp_flags;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_fi;
    logic [6:0]  alu_op;
    logic [7:0]  alu_d;
    logic [7:0]  alu_fo;

    logic [8:0]  sum9;
    logic [1:0]  fi_seen;
    logic [6:0]  op_seen;
    int          total;
    int          bad;

`ifdef ALU_BYTE_SEQUENCER_OVF_EN
    localparam logic [7:0] OvfBit = 8'h08;
`else
    localparam logic [7:0] OvfBit = 8'h00;
`endif

    alu_byte_sequencer #(.BYTES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_d     (rsp_d),
        .rsp_flags (rsp_flags),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_fi    (alu_fi),
        .alu_op    (alu_op),
        .alu_d     (alu_d),
        .alu_fo    (alu_fo)
    );

    // Reference ALU: fo[0] is carry for add, borrow (bit 8 of the difference) for sub.
    always_comb begin
        sum9   = 9'd0;
        alu_d  = 8'h00;
        alu_fo = 8'h00;
        case (alu_op)
            7'b0000001: begin
                sum9      = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_fi[0]};
                alu_d     = sum9[7:0];
                alu_fo[0] = sum9[8];
            end
            7'b0000010: begin
                sum9      = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_fi[0]};
                alu_d     = sum9[7:0];
                alu_fo[0] = sum9[8];
            end
            7'b0000100: alu_d = alu_a & alu_b;
            7'b0001000: alu_d = alu_a | alu_b;
            7'b0010000: alu_d = ~alu_a;
            default:    alu_d = 8'h00;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE, check latency, result and flags, then complete the handshake.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] ed, input logic [7:0] ef);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (op != 3'd7) begin
            for (int k = 0; k < 2; k++) begin
                check({tag, "_early"}, 32'(rsp_valid), 32'd0);
                fi_seen[k] = alu_fi[0];
                op_seen    = alu_op;
                @(posedge clk); #1;
            end
        end
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_d"}, 32'(rsp_d), 32'(ed));
        check({tag, "_flags"}, 32'(rsp_flags), 32'(ef));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_release"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        fi_seen   = 2'b00;
        op_seen   = 7'd0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        rsp_ready = 1'b0;
        #2;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_d", 32'(rsp_d), 32'd0);
        check("rst_flags", 32'(rsp_flags), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_fi, 1'b0, alu_op}), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_c8", 3'd0, 16'h00FF, 16'h0001, 16'h0100, 8'h04);
        check("add_c8_fi0", 32'(fi_seen[0]), 32'd0);
        check("add_c8_fi1", 32'(fi_seen[1]), 32'd1);
        check("add_c8_op", 32'(op_seen), 32'h01);
        run_op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 8'h03);
        run_op("adc_cin", 3'd1, 16'h0000, 16'h0000, 16'h0001, 8'h04);
        check("adc_cin_fi0", 32'(fi_seen[0]), 32'd1);
        run_op("sub_brw", 3'd2, 16'h0000, 16'h0001, 16'hFFFF, 8'h01);
        check("sub_op", 32'(op_seen), 32'h02);
        run_op("sbc_brw", 3'd3, 16'h0005, 16'h0001, 16'h0003, 8'h04);
        run_op("add_set", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 8'h03);
        run_op("not", 3'd6, 16'h00F0, 16'h1234, 16'hFF0F, 8'h01);
        check("not_op", 32'(op_seen), 32'h10);
        run_op("adc_after_not", 3'd1, 16'h0000, 16'h0000, 16'h0001, 8'h04);
        run_op("and", 3'd4, 16'h0F0F, 16'h00FF, 16'h000F, 8'h04);
        run_op("or_neg", 3'd5, 16'h8000, 16'h0001, 16'h8001, 8'h00);
        run_op("and_zero", 3'd4, 16'h1234, 16'h0000, 16'h0000, 8'h02);
        run_op("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 16'h8000, OvfBit);
        run_op("sub_ovf", 3'd2, 16'h8000, 16'h0001, 16'h7FFF, 8'h04 | OvfBit);

        // Backpressure: a second request waits while the first response is held.
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 16'h1111;
        req_b     = 16'h2222;
        @(posedge clk); #1;
        req_op = 3'd2;
        req_a  = 16'h0005;
        req_b  = 16'h0003;
        repeat (2) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_d", 32'(rsp_d), 32'h3333);
            check("bp_flags", 32'(rsp_flags), 32'h04);
            check("bp_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_idle_ready", 32'(req_ready), 32'd1);
        check("bp_idle_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_second_busy", 32'(req_ready), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("bp_second_valid", 32'(rsp_valid), 32'd1);
        check("bp_second_d", 32'(rsp_d), 32'h0002);
        check("bp_second_flags", 32'(rsp_flags), 32'h04);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset in the middle of a walk abandons it and clears the carry register.
        run_op("pre_rst", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 8'h03);
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 16'h1234;
        req_b     = 16'h1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid_run_op", 32'(alu_op), 32'h01);
        rst_n = 1'b0;
        #1;
        check("mid_rst_alu", 32'({alu_a, alu_b, alu_fi, 1'b0, alu_op}), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_d", 32'(rsp_d), 32'd0);
        check("mid_rst_flags", 32'(rsp_flags), 32'd0);
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        run_op("adc_post_rst", 3'd1, 16'h0000, 16'h0000, 16'h0000, 8'h02);

        // Reserved opcode: immediate response, carry register untouched.
        run_op("set_c", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 8'h03);
        run_op("rsv", 3'd7, 16'hAAAA, 16'h5555, 16'h0000, 8'h82);
        run_op("adc_post_rsv", 3'd1, 16'h0000, 16'h0000, 16'h0001, 8'h04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_byte_sequencer.md
Name: alu_byte_sequencer

Overview:
- Issue/collect stage wrapped around the 8-bit combinational ALU.
- Accepts multi-byte operations through a valid/ready request port and drives the ALU one byte per cycle, LSB first.
- Chains the carry/borrow between bytes through the ALU flag input, then assembles the wide result and aggregate flags.
- Returns result and flags on a valid/ready response port. Holds the architectural carry flag used by ADC/SBC.

Parameters:
- BYTES, 2, operand width in bytes (legal 1..4); datapath width W = 8*BYTES.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request valid.
- req_ready  output  1  request ready.
- req_op  input  3  operation: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 NOT, 7 reserved.
- req_a  input  W  operand A.
- req_b  input  W  operand B (ignored for NOT).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response ready.
- rsp_d  output  W  result.
- rsp_flags  output  8  bit0 carry/borrow, bit1 zero, bit2 positive (signed > 0), bit3 overflow (optional), bit7 illegal op, others 0.
- alu_a  output  8  ALU operand a.
- alu_b  output  8  ALU operand b.
- alu_fi  output  8  ALU flag input; bit0 = chain carry, others 0.
- alu_op  output  7  ALU one-hot op: add 0000001, sub 0000010, and 0000100, or 0001000, not 0010000.
- alu_d  input  8  ALU result byte.
- alu_fo  input  8  ALU flag output; only bit0 is used.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low; all state and registered outputs clear immediately on assertion.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_d=0, rsp_flags=0, carry register=0, alu_a/alu_b/alu_fi/alu_op=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1, alu_op=0.
  - On req_valid: latch req_op/req_a/req_b, set byte index=0, zero accumulator=1, and enter RUN.
  - Initial chain carry: 0 for ADD/SUB; carry register for ADC/SBC.
  - op 7 goes straight to DONE with rsp_d=0 and rsp_flags=0x82; the carry register is unchanged.
- RUN:
  - req_ready=0.
  - Combinationally drive alu_a/alu_b = latched byte[index], alu_fi[0] = chain carry, alu_op per opcode.
  - Each edge: store alu_d into result byte[index] and AND (alu_d==0) into the zero accumulator.
  - Arithmetic ops: chain carry <= alu_fo[0]. Logic ops: alu_fo is ignored and chain carry is held.
  - index==BYTES-1 -> DONE; otherwise index+1.
- DONE:
  - rsp_valid=1; rsp_d and rsp_flags stay stable until rsp_ready=1.
  - At the handshake edge -> IDLE.
  - The carry register updates to the final chain carry only for ADD/ADC/SUB/SBC, at the edge entering DONE.
- Latency: rsp_valid rises BYTES edges after the accepting edge. Throughput is one request per BYTES+2 cycles with no backpressure. No request is accepted in RUN or DONE.
- Flags:
  - bit0 = final carry for arithmetic ops (for SUB/SBC it is the borrow, i.e. bit 8 of the ALU subtraction); carry register value for logic ops.
  - bit1 = all W result bits zero.
  - bit2 = result MSB 0 and not zero.
- Width: arithmetic wraps modulo 2^W. NOT inverts A bytewise.
- Reset mid-RUN or mid-DONE: the operation is abandoned, no response is issued, and the carry register clears.

Optional Feature:
- Macro: ALU_BYTE_SEQUENCER_OVF_EN.
- Defined: rsp_flags[3] is signed overflow for ADD/ADC/SUB/SBC.
  - Add: A and B have the same MSB and the result MSB differs.
  - Sub: A and B have different MSBs and the result MSB differs from A's MSB.
  - Logic ops: 0.
- Undefined: rsp_flags[3] is tied 0 and no overflow logic is built.

Test Plan:
- BYTES=2, ADD 0x00FF+0x0001 -> rsp_d=0x0100, flags=0x04; rsp_valid 2 edges after accept; alu_fi[0]=1 on byte 1.
- ADD 0xFFFF+0x0001 -> 0x0000, flags=0x03; then ADC 0x0000+0x0000 -> 0x0001, flags=0x04.
- SUB 0x0000-0x0001 -> 0xFFFF, flags=0x01; then SBC 0x0005-0x0001 -> 0x0003, flags=0x04.
- Carry register=1, NOT 0x00F0 -> 0xFF0F, flags=0x01; alu_op=0010000 during RUN; a following ADC 0+0 -> 0x0001.
- Hold rsp_ready=0 for 5 cycles with a second req_valid pending -> rsp_d/rsp_flags stable, req_ready=0; second request accepted only after the handshake.
- Assert rst_n low mid-RUN -> outputs zero at once, carry register 0, no response. Then op 7 -> rsp_d=0, flags=0x82. With ALU_BYTE_SEQUENCER_OVF_EN defined, ADD 0x7FFF+0x0001 -> 0x8000, flags bit3=1.
